// File: rtl/perf_counter_ctrl_pkg.sv
// Shared types and sizing for the perf-counter bank access controller.
package perf_counter_ctrl_pkg;
   localparam int          NR_PERF_COUNTERS  = 14;
   localparam logic [4:0]  PERF_FIRST_ADDR   = 5'd3;
   localparam int          PERF_STARVE_LIMIT = 4;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [63:0] wdata;
   } perf_req_t;

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} pc_state_e;
endpackage

// File: rtl/perf_counter_ctrl_if.sv
// Requester (CSR, debug), clear control and bank-port signals of the perf-counter controller.
interface perf_counter_ctrl_if;
   logic        csr_req_i, csr_we_i;
   logic [4:0]  csr_addr_i;
   logic [63:0] csr_wdata_i;
   logic        csr_gnt_o, csr_rvalid_o;
   logic [63:0] csr_rdata_o;
   logic        dbg_req_i, dbg_we_i;
   logic [4:0]  dbg_addr_i;
   logic [63:0] dbg_wdata_i;
   logic        dbg_gnt_o, dbg_rvalid_o;
   logic [63:0] dbg_rdata_o;
   logic        clear_i, clear_busy_o;
   logic [4:0]  pc_addr_o;
   logic        pc_we_o;
   logic [63:0] pc_wdata_o;
   logic [63:0] pc_rdata_i;

   modport slave (
      input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
      output csr_gnt_o, csr_rvalid_o, csr_rdata_o,
      input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
      input  clear_i, output clear_busy_o,
      output pc_addr_o, pc_we_o, pc_wdata_o,
      input  pc_rdata_i
   );

   modport master (
      output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
      input  csr_gnt_o, csr_rvalid_o, csr_rdata_o,
      output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o,
      output clear_i, input clear_busy_o,
      input  pc_addr_o, pc_we_o, pc_wdata_o,
      output pc_rdata_i
   );
endinterface

// File: rtl/perf_counter_ctrl.sv
// Perf-counter bank port controller: CSR-priority arbiter with a debug starvation guard,
// plus a bulk-clear sequencer that walks every counter writing zero.
import perf_counter_ctrl_pkg::*;

module perf_counter_ctrl #(
   parameter logic [4:0] FIRST_ADDR   = PERF_FIRST_ADDR,
   parameter int         NR_COUNTERS  = NR_PERF_COUNTERS,
   parameter int         STARVE_LIMIT = PERF_STARVE_LIMIT
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   perf_counter_ctrl_if.slave  bus
);
   localparam int CLR_W    = $clog2(NR_COUNTERS);
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   function automatic logic in_range(input logic [4:0] a);
      return (int'(a) >= int'(FIRST_ADDR)) && (int'(a) < int'(FIRST_ADDR) + NR_COUNTERS);
   endfunction

   pc_state_e           state_q, state_d;
   logic [CLR_W-1:0]    clr_idx_q;
   logic [STARVE_W-1:0] starve_q;
   logic                csr_gnt, dbg_gnt, starve_hit, clr_last;
   perf_req_t           csr_req, dbg_req, win;
   logic                csr_rvalid_q, dbg_rvalid_q;
   logic [63:0]         csr_rdata_q, dbg_rdata_q;

   assign csr_req    = '{we: bus.csr_we_i, addr: bus.csr_addr_i, wdata: bus.csr_wdata_i};
   assign dbg_req    = '{we: bus.dbg_we_i, addr: bus.dbg_addr_i, wdata: bus.dbg_wdata_i};
   assign starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));
   assign clr_last   = (clr_idx_q == CLR_W'(NR_COUNTERS - 1));

   always_comb begin
      state_d        = state_q;
      csr_gnt        = 1'b0;
      dbg_gnt        = 1'b0;
      win            = csr_req;
      bus.pc_addr_o  = FIRST_ADDR;
      bus.pc_we_o    = 1'b0;
      bus.pc_wdata_o = '0;
      case (state_q)
         IDLE: begin
            // Debug wins only when alone or once it has lost STARVE_LIMIT times in a row.
            if (bus.dbg_req_i && (!bus.csr_req_i || starve_hit)) dbg_gnt = 1'b1;
            else if (bus.csr_req_i)                             csr_gnt = 1'b1;
            if (dbg_gnt) win = dbg_req;
            if (csr_gnt || dbg_gnt) begin
               bus.pc_addr_o  = win.addr;
               bus.pc_we_o    = win.we && in_range(win.addr);
               bus.pc_wdata_o = win.wdata;
            end
            if (bus.clear_i) state_d = CLEAR;
         end
         CLEAR: begin
            bus.pc_we_o   = 1'b1;
            bus.pc_addr_o = FIRST_ADDR + 5'(clr_idx_q);
            if (clr_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         clr_idx_q <= '0;
         starve_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == CLEAR) clr_idx_q <= clr_last ? '0 : clr_idx_q + 1'b1;
         // Starvation count is frozen while the clear owns the port.
         if (state_q == IDLE) begin
            if (!bus.dbg_req_i || dbg_gnt) starve_q <= '0;
            else if (!starve_hit)          starve_q <= starve_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         csr_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         csr_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         csr_rvalid_q <= csr_gnt;
         dbg_rvalid_q <= dbg_gnt;
         // Captured in the grant cycle, so a write reports the pre-write value.
         if (csr_gnt) csr_rdata_q <= in_range(csr_req.addr) ? bus.pc_rdata_i : '0;
         if (dbg_gnt) dbg_rdata_q <= in_range(dbg_req.addr) ? bus.pc_rdata_i : '0;
      end
   end

   assign bus.csr_gnt_o    = csr_gnt;
   assign bus.dbg_gnt_o    = dbg_gnt;
   assign bus.csr_rvalid_o = csr_rvalid_q;
   assign bus.dbg_rvalid_o = dbg_rvalid_q;
   assign bus.csr_rdata_o  = csr_rdata_q;
   assign bus.dbg_rdata_o  = dbg_rdata_q;
   assign bus.clear_busy_o = (state_q == CLEAR);
endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Self-checking bench: bank model, scoreboard of expected read data per requester.
module tb_perf_counter_ctrl;
   logic clk = 1'b0;
   logic rst_ni;
   always #5 clk = ~clk;

   perf_counter_ctrl_if bus ();
   perf_counter_ctrl dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

   logic [63:0] mem  [32];
   logic [63:0] refm [32];
   logic [63:0] csr_q[$], dbg_q[$];
   logic        csr_gd, dbg_gd;
   int n_vec = 0, n_err = 0;

   assign bus.pc_rdata_i = mem[bus.pc_addr_o];
   always @(posedge clk) if (bus.pc_we_o) mem[bus.pc_addr_o] <= bus.pc_wdata_o;

   function automatic logic in_rng(input logic [4:0] a);
      return (a >= 5'd3) && (a <= 5'd16);
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
      end
   endtask

   // Scoreboard: push expected rdata on grant, pop on rvalid; rvalid must trail grant by one cycle.
   always @(negedge clk) begin
      if (!rst_ni) begin
         csr_gd = 1'b0;
         dbg_gd = 1'b0;
      end else begin
         chk("csr_rvalid", 64'(bus.csr_rvalid_o), 64'(csr_gd));
         chk("dbg_rvalid", 64'(bus.dbg_rvalid_o), 64'(dbg_gd));
         if (bus.csr_rvalid_o) begin
            if (csr_q.size() == 0) chk("csr_q_underflow", 64'd1, 64'd0);
            else chk("csr_rdata", bus.csr_rdata_o, csr_q.pop_front());
         end
         if (bus.dbg_rvalid_o) begin
            if (dbg_q.size() == 0) chk("dbg_q_underflow", 64'd1, 64'd0);
            else chk("dbg_rdata", bus.dbg_rdata_o, dbg_q.pop_front());
         end
         if (bus.csr_gnt_o) begin
            csr_q.push_back(in_rng(bus.csr_addr_i) ? refm[bus.csr_addr_i] : 64'd0);
            if (bus.csr_we_i && in_rng(bus.csr_addr_i)) refm[bus.csr_addr_i] = bus.csr_wdata_i;
         end
         if (bus.dbg_gnt_o) begin
            dbg_q.push_back(in_rng(bus.dbg_addr_i) ? refm[bus.dbg_addr_i] : 64'd0);
            if (bus.dbg_we_i && in_rng(bus.dbg_addr_i)) refm[bus.dbg_addr_i] = bus.dbg_wdata_i;
         end
         csr_gd = bus.csr_gnt_o;
         dbg_gd = bus.dbg_gnt_o;
      end
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_csr_gnt"}, 64'(bus.csr_gnt_o), 64'd0);
      chk({tag, "_dbg_gnt"}, 64'(bus.dbg_gnt_o), 64'd0);
      chk({tag, "_csr_rvalid"}, 64'(bus.csr_rvalid_o), 64'd0);
      chk({tag, "_dbg_rvalid"}, 64'(bus.dbg_rvalid_o), 64'd0);
      chk({tag, "_csr_rdata"}, bus.csr_rdata_o, 64'd0);
      chk({tag, "_dbg_rdata"}, bus.dbg_rdata_o, 64'd0);
      chk({tag, "_busy"}, 64'(bus.clear_busy_o), 64'd0);
      chk({tag, "_pc_addr"}, 64'(bus.pc_addr_o), 64'd3);
      chk({tag, "_pc_we"}, 64'(bus.pc_we_o), 64'd0);
      chk({tag, "_pc_wdata"}, bus.pc_wdata_o, 64'd0);
   endtask

   // Called just after a rising edge; leaves the bench just after the next one.
   task automatic csr_access(input logic we, input logic [4:0] a, input logic [63:0] d);
      bus.csr_we_i = we; bus.csr_addr_i = a; bus.csr_wdata_i = d; bus.csr_req_i = 1'b1;
      @(negedge clk);
      chk("csr_gnt", 64'(bus.csr_gnt_o), 64'd1);
      chk("csr_pc_addr", 64'(bus.pc_addr_o), 64'(a));
      chk("csr_pc_we", 64'(bus.pc_we_o), 64'(we && in_rng(a)));
      if (we) chk("csr_pc_wdata", bus.pc_wdata_o, d);
      @(posedge clk); #1;
      bus.csr_req_i = 1'b0;
   endtask

   task automatic dbg_access(input logic we, input logic [4:0] a, input logic [63:0] d);
      bus.dbg_we_i = we; bus.dbg_addr_i = a; bus.dbg_wdata_i = d; bus.dbg_req_i = 1'b1;
      @(negedge clk);
      chk("dbg_gnt", 64'(bus.dbg_gnt_o), 64'd1);
      chk("dbg_pc_we", 64'(bus.pc_we_o), 64'(we && in_rng(a)));
      @(posedge clk); #1;
      bus.dbg_req_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]  <= 64'h1000 + 64'(i);
         refm[i] = 64'h1000 + 64'(i);
      end
      mem[5] <= 64'h1234; refm[5] = 64'h1234;
      mem[3] <= 64'h7;    refm[3] = 64'h7;
      rst_ni = 1'b0;
      bus.csr_req_i = 0; bus.csr_we_i = 0; bus.csr_addr_i = 0; bus.csr_wdata_i = 0;
      bus.dbg_req_i = 0; bus.dbg_we_i = 0; bus.dbg_addr_i = 0; bus.dbg_wdata_i = 0;
      bus.clear_i = 0;
      repeat (2) @(negedge clk);
      chk_reset_outputs("rst");
      @(posedge clk); #1 rst_ni = 1'b1;

      // CSR read of a preloaded counter
      csr_access(1'b0, 5'd5, 64'd0);
      @(negedge clk);
      chk("t1_rdata", bus.csr_rdata_o, 64'h1234);
      @(posedge clk); #1;

      // CSR write returns the old value; a later read sees the new one
      csr_access(1'b1, 5'd3, 64'hDEAD);
      @(negedge clk);
      chk("t2_old", bus.csr_rdata_o, 64'h7);
      @(posedge clk); #1;
      csr_access(1'b0, 5'd3, 64'd0);
      @(negedge clk);
      chk("t2_new", bus.csr_rdata_o, 64'hDEAD);
      @(posedge clk); #1;

      // Both requesting: 4 CSR grants then 1 debug grant, repeating
      bus.csr_we_i = 0; bus.csr_addr_i = 5'd5; bus.csr_req_i = 1;
      bus.dbg_we_i = 0; bus.dbg_addr_i = 5'd6; bus.dbg_req_i = 1;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         chk("t3_csr_gnt", 64'(bus.csr_gnt_o), 64'((k % 5) != 4));
         chk("t3_dbg_gnt", 64'(bus.dbg_gnt_o), 64'((k % 5) == 4));
         @(posedge clk); #1;
      end
      bus.csr_req_i = 0; bus.dbg_req_i = 0;

      // Debug write out of range: granted, no bank write, rdata 0
      dbg_access(1'b1, 5'd20, 64'hBEEF);
      @(negedge clk);
      chk("t6_rdata", bus.dbg_rdata_o, 64'd0);
      chk("t6_mem20", mem[20], 64'h1014);
      @(posedge clk); #1;

      // Clear with a same-cycle CSR request
      bus.clear_i = 1; bus.csr_we_i = 0; bus.csr_addr_i = 5'd4; bus.csr_req_i = 1;
      @(negedge clk);
      chk("t4_csr_gnt", 64'(bus.csr_gnt_o), 64'd1);
      chk("t4_busy0", 64'(bus.clear_busy_o), 64'd0);
      @(posedge clk); #1;
      bus.clear_i = 0; bus.csr_req_i = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         chk("t4_busy", 64'(bus.clear_busy_o), 64'd1);
         chk("t4_we", 64'(bus.pc_we_o), 64'd1);
         chk("t4_addr", 64'(bus.pc_addr_o), 64'(3 + i));
         chk("t4_wdata", bus.pc_wdata_o, 64'd0);
      end
      for (int a = 3; a <= 16; a++) refm[a] = 64'd0;
      @(negedge clk);
      chk("t4_done", 64'(bus.clear_busy_o), 64'd0);
      chk("t4_mem16", mem[16], 64'd0);
      @(posedge clk); #1;

      // CSR request held during a clear waits for the first idle cycle
      bus.clear_i = 1;
      @(negedge clk);
      @(posedge clk); #1;
      bus.clear_i = 0; bus.csr_we_i = 0; bus.csr_addr_i = 5'd7; bus.csr_req_i = 1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         chk("t5_gnt", 64'(bus.csr_gnt_o), 64'd0);
         chk("t5_busy", 64'(bus.clear_busy_o), 64'd1);
      end
      @(negedge clk);
      chk("t5_gnt_idle", 64'(bus.csr_gnt_o), 64'd1);
      chk("t5_busy_idle", 64'(bus.clear_busy_o), 64'd0);
      @(posedge clk); #1;
      bus.csr_req_i = 0;

      // Reset in the middle of a clear
      for (int a = 3; a <= 16; a++) csr_access(1'b1, 5'(a), 64'hA0 + 64'(a));
      @(negedge clk);
      @(posedge clk); #1;
      bus.clear_i = 1;
      @(posedge clk); #1;
      bus.clear_i = 0;
      repeat (5) @(posedge clk);
      #1 rst_ni = 1'b0;
      #1 chk_reset_outputs("t7_async");
      @(negedge clk);
      chk_reset_outputs("t7");
      @(posedge clk); #1 rst_ni = 1'b1;
      for (int a = 3; a <= 16; a++)
         chk("t7_mem", mem[a], (a < 8) ? 64'd0 : 64'hA0 + 64'(a));
      for (int a = 3; a < 8; a++) refm[a] = 64'd0;
      csr_access(1'b0, 5'd9, 64'd0);
      @(negedge clk);
      chk("t7_read9", bus.csr_rdata_o, 64'hA9);

      repeat (2) @(negedge clk);
      chk("csr_q_left", 64'(csr_q.size()), 64'd0);
      chk("dbg_q_left", 64'(dbg_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
